// File: rtl/vec_pkg.sv
// Shared state encoding, vector layout helpers and LFSR constants for vector_sequencer.
package vec_pkg;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, RAND, DONE} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 seen from the output end of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Layout LSB->MSB: d_exp, out_exp, data_out_exp, x, b, a, data_in
    function automatic int unsigned vec_w(input int unsigned width, input int unsigned x_w);
        return 2 * width + x_w + 4;
    endfunction

    function automatic int unsigned off_x(input int unsigned width);
        return width + 2;
    endfunction

    function automatic int unsigned off_b(input int unsigned width, input int unsigned x_w);
        return width + x_w + 2;
    endfunction

    function automatic int unsigned off_a(input int unsigned width, input int unsigned x_w);
        return width + x_w + 3;
    endfunction

    function automatic int unsigned off_din(input int unsigned width, input int unsigned x_w);
        return width + x_w + 4;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/vector_sequencer_exp_delay.sv
// LAT-deep shift register carrying {valid, index, expected fields}; only valid bits are reset.
module exp_delay #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [EXP_W-1:0] out_exp,
    output logic             busy_c
);

    logic [LAT-1:0]   valid_q;
    logic [IDX_W-1:0] idx_q [LAT];
    logic [EXP_W-1:0] exp_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        idx_q[0] <= in_idx;
        exp_q[0] <= in_exp;
        for (int i = 1; i < int'(LAT); i++) begin
            idx_q[i] <= idx_q[i-1];
            exp_q[i] <= exp_q[i-1];
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];
    assign out_exp   = exp_q[LAT-1];
    assign busy_c    = |valid_q;

endmodule

// File: rtl/vector_sequencer.sv
// Table-driven stimulus/response engine with a trailing LFSR random-stimulus phase.
module vector_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned X_W         = 5,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LAT         = 1,
    parameter int unsigned RAND_CYCLES = 30,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned NW    = AW + 1,
    localparam int unsigned VEC_W = vec_w(WIDTH, X_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [VEC_W-1:0] load_data,
    input  logic [NW-1:0]    num_vec,
    input  logic             start,
    output logic [WIDTH-1:0] data_in_o,
    output logic             a_o,
    output logic             b_o,
    output logic [X_W-1:0]   x_o,
    input  logic [WIDTH-1:0] data_out_i,
    input  logic             out_i,
    input  logic             d_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [AW-1:0]    fail_idx,
    output logic [NW-1:0]    vecnum,
    output logic [15:0]      errors
);

    localparam int unsigned EXP_W   = WIDTH + 2;
    localparam int unsigned RW      = (RAND_CYCLES > 1) ? $clog2(RAND_CYCLES + 1) : 1;
    localparam int unsigned OFF_X   = off_x(WIDTH);
    localparam int unsigned OFF_B   = off_b(WIDTH, X_W);
    localparam int unsigned OFF_A   = off_a(WIDTH, X_W);
    localparam int unsigned OFF_DIN = off_din(WIDTH, X_W);

    state_t           state_q, state_d;
    logic             accept_c;
    logic [VEC_W-1:0] vec_table [DEPTH];
    logic [VEC_W-1:0] cur_vec;
    logic [AW-1:0]    issue_idx;
    logic [NW-1:0]    run_len;
    logic [NW-1:0]    num_clamped;
    logic [RW-1:0]    rand_cnt;
    logic [15:0]      lfsr_q;
    logic             last_issue;
    logic             rand_last;
    logic             pipe_valid;
    logic             pipe_busy;
    logic [AW-1:0]    pipe_idx;
    logic [EXP_W-1:0] pipe_exp;
    logic             miscmp_c;

    assign cur_vec     = vec_table[issue_idx];
    assign num_clamped = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
    assign last_issue  = (NW'(issue_idx) + NW'(1)) == run_len;
    assign rand_last   = rand_cnt == RW'(RAND_CYCLES - 1);
    assign miscmp_c    = pipe_valid && ({data_out_i, out_i, d_i} != pipe_exp);

    // Vector table: not reset, writable only while idle
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            vec_table[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (num_vec != '0)         state_d = RUN;
                    else if (RAND_CYCLES != 0) state_d = RAND;
                    else                       state_d = DONE;
                end
            end
            RUN:   if (last_issue) state_d = DRAIN;
            DRAIN: if (!pipe_busy) state_d = (RAND_CYCLES != 0) ? RAND : DONE;
            RAND:  if (rand_last)  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Issue pointer, run length, random-phase counter and LFSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_idx <= '0;
            run_len   <= '0;
            rand_cnt  <= '0;
            lfsr_q    <= LFSR_SEED;
        end else if (accept_c) begin
            issue_idx <= '0;
            run_len   <= num_clamped;
            rand_cnt  <= '0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            if (state_q == RUN) issue_idx <= issue_idx + AW'(1);
            if (state_q == RAND) begin
                rand_cnt <= rand_cnt + RW'(1);
                lfsr_q   <= lfsr_next(lfsr_q);
            end
        end
    end

    // Stimulus outputs hold their value outside RUN/RAND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_in_o <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            x_o       <= '0;
        end else if (state_q == RUN) begin
            data_in_o <= cur_vec[OFF_DIN +: WIDTH];
            a_o       <= cur_vec[OFF_A];
            b_o       <= cur_vec[OFF_B];
            x_o       <= cur_vec[OFF_X +: X_W];
        end else if (state_q == RAND) begin
            data_in_o <= lfsr_q[WIDTH-1:0];
            a_o       <= lfsr_q[8];
            b_o       <= lfsr_q[9];
            x_o       <= lfsr_q[X_W+9:10];
        end
    end

    exp_delay #(
        .LAT   (LAT),
        .IDX_W (AW),
        .EXP_W (EXP_W)
    ) u_exp_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state_q == RUN),
        .in_idx    (issue_idx),
        .in_exp    (cur_vec[EXP_W-1:0]),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx),
        .out_exp   (pipe_exp),
        .busy_c    (pipe_busy)
    );

    // Compare results and saturating error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
            vecnum   <= '0;
            errors   <= '0;
            fail_idx <= '0;
        end else begin
            mismatch <= miscmp_c;
            if (accept_c) begin
                vecnum   <= '0;
                errors   <= '0;
                fail_idx <= '0;
            end else if (pipe_valid) begin
                vecnum <= vecnum + NW'(1);
                if (miscmp_c) begin
                    fail_idx <= pipe_idx;
                    if (errors != 16'hFFFF) errors <= errors + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= (state_d == RUN) || (state_d == DRAIN) || (state_d == RAND);
            done <= (state_d == DONE);
            pass <= (state_d == DONE) && (accept_c || errors == 16'd0);
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Randomized self-checking bench for vector_sequencer: three instances (LAT=1, LAT=3, random phase).
module tb_vector_sequencer;

    localparam int D   = 16;
    localparam int MAX = 400;

    typedef struct packed {
        logic [7:0] din;
        logic       a;
        logic       b;
        logic [4:0] x;
        logic [7:0] dexp;
        logic       oexp;
        logic       bexp;
    } tvec_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] load_en, start, busy, done, pass, mismatch, a_o, b_o, out_i, d_i;
    logic [3:0] load_addr;
    tvec_t      load_data;
    logic [2:0][4:0]  num_vec, vecnum, x_o;
    logic [2:0][7:0]  din_o, dout_i;
    logic [2:0][3:0]  fail_idx;
    logic [2:0][15:0] errors;
    logic [7:0] dly_d1, dly_d2;
    logic       dly_a1, dly_a2, dly_b1, dly_b2;

    tvec_t       tbl [3][D];
    int          mm_cnt [3];
    int          mm_idx [3];
    logic [14:0] stim_log [MAX+1];
    int          checks = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    vector_sequencer #(.LAT(1), .RAND_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .load_en(load_en[0]), .load_addr(load_addr), .load_data(load_data),
        .num_vec(num_vec[0]), .start(start[0]), .data_in_o(din_o[0]), .a_o(a_o[0]), .b_o(b_o[0]),
        .x_o(x_o[0]), .data_out_i(dout_i[0]), .out_i(out_i[0]), .d_i(d_i[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .mismatch(mismatch[0]), .fail_idx(fail_idx[0]),
        .vecnum(vecnum[0]), .errors(errors[0]));

    vector_sequencer #(.LAT(3), .RAND_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .load_en(load_en[1]), .load_addr(load_addr), .load_data(load_data),
        .num_vec(num_vec[1]), .start(start[1]), .data_in_o(din_o[1]), .a_o(a_o[1]), .b_o(b_o[1]),
        .x_o(x_o[1]), .data_out_i(dout_i[1]), .out_i(out_i[1]), .d_i(d_i[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .mismatch(mismatch[1]), .fail_idx(fail_idx[1]),
        .vecnum(vecnum[1]), .errors(errors[1]));

    vector_sequencer #(.LAT(1), .RAND_CYCLES(30)) u_dut2 (
        .clk(clk), .rst(rst), .load_en(load_en[2]), .load_addr(load_addr), .load_data(load_data),
        .num_vec(num_vec[2]), .start(start[2]), .data_in_o(din_o[2]), .a_o(a_o[2]), .b_o(b_o[2]),
        .x_o(x_o[2]), .data_out_i(dout_i[2]), .out_i(out_i[2]), .d_i(d_i[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .mismatch(mismatch[2]), .fail_idx(fail_idx[2]),
        .vecnum(vecnum[2]), .errors(errors[2]));

    // Loopback response paths; instance 1 sees two extra register stages
    assign dout_i[0] = din_o[0];
    assign out_i[0]  = a_o[0];
    assign d_i[0]    = b_o[0];
    assign dout_i[2] = din_o[2];
    assign out_i[2]  = a_o[2];
    assign d_i[2]    = b_o[2];
    assign dout_i[1] = dly_d2;
    assign out_i[1]  = dly_a2;
    assign d_i[1]    = dly_b2;

    always @(posedge clk) begin
        dly_d1 <= din_o[1]; dly_d2 <= dly_d1;
        dly_a1 <= a_o[1];   dly_a2 <= dly_a1;
        dly_b1 <= b_o[1];   dly_b2 <= dly_b1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mismatch[i]) begin
                mm_cnt[i] = mm_cnt[i] + 1;
                mm_idx[i] = int'(fail_idx[i]);
            end
        end
    end

    function automatic logic [14:0] stim(input int i);
        return {din_o[i], a_o[i], b_o[i], x_o[i]};
    endfunction

    function automatic logic [14:0] vec_stim(input tvec_t v);
        return {v.din, v.a, v.b, v.x};
    endfunction

    function automatic logic [14:0] word_stim(input logic [15:0] w);
        return {w[7:0], w[8], w[9], w[14:10]};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    function automatic tvec_t good_vec();
        tvec_t v;
        v.din  = 8'($urandom_range(1, 255));
        v.a    = 1'($urandom_range(0, 1));
        v.b    = 1'($urandom_range(0, 1));
        v.x    = 5'($urandom_range(0, 31));
        v.dexp = v.din;
        v.oexp = v.a;
        v.bexp = v.b;
        return v;
    endfunction

    function automatic tvec_t corrupt(input tvec_t v);
        tvec_t c = v;
        case ($urandom_range(0, 2))
            0:       c.dexp = v.dexp ^ 8'(1 << $urandom_range(0, 7));
            1:       c.oexp = ~v.oexp;
            default: c.bexp = ~v.bexp;
        endcase
        return c;
    endfunction

    // Reference: a loopback DUT returns exactly the stimulus of each vector
    task automatic model_run(input int inst, input int n, output int errs, output int last_fail);
        int eff = (n > D) ? D : n;
        errs = 0;
        last_fail = 0;
        for (int k = 0; k < eff; k++) begin
            if ({tbl[inst][k].dexp, tbl[inst][k].oexp, tbl[inst][k].bexp} !=
                {tbl[inst][k].din, tbl[inst][k].a, tbl[inst][k].b}) begin
                errs++;
                last_fail = k;
            end
        end
    endtask

    task automatic load_vec(input int inst, input int addr, input tvec_t v);
        load_en[inst] = 1'b1;
        load_addr     = 4'(addr);
        load_data     = v;
        @(negedge clk);
        load_en[inst] = 1'b0;
        tbl[inst][addr] = v;
    endtask

    // Starts a run, logs stimulus after every edge, optionally pokes start/load mid-run.
    // cyc = index of the edge (start edge = 0) after which done was first seen.
    task automatic run(input int inst, input int n, input int poke_cyc, input tvec_t poke_vec,
                       output int cyc, output logic busy0, output logic done0);
        mm_cnt[inst] = 0;
        mm_idx[inst] = -1;
        num_vec[inst] = 5'(n);
        start[inst]   = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
        cyc   = 0;
        busy0 = busy[inst];
        done0 = done[inst];
        stim_log[0] = stim(inst);
        while (!done[inst] && cyc < MAX) begin
            if (cyc == poke_cyc) begin
                start[inst]   = 1'b1;
                num_vec[inst] = 5'd1;
                load_en[inst] = 1'b1;
                load_addr     = 4'd5;
                load_data     = poke_vec;
            end
            @(negedge clk);
            start[inst]   = 1'b0;
            load_en[inst] = 1'b0;
            cyc++;
            stim_log[cyc] = stim(inst);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_en = '0; start = '0; num_vec = '0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy[i], done[i], pass[i], mismatch[i]} !== 4'b0) begin
                n_err++; $display("FAIL reset_flags inst%0d: got %b expected 0000", i, {busy[i], done[i], pass[i], mismatch[i]});
            end
            checks++;
            if ({vecnum[i], fail_idx[i], errors[i]} !== 25'd0) begin
                n_err++; $display("FAIL reset_counts inst%0d: got %h expected 0", i, {vecnum[i], fail_idx[i], errors[i]});
            end
            checks++;
            if (stim(i) !== 15'd0) begin
                n_err++; $display("FAIL reset_stim inst%0d: got %h expected 0", i, stim(i));
            end
        end
    endtask

    task automatic test_loopback();
        int cyc; logic b0, d0;
        for (int k = 0; k < 4; k++) load_vec(0, k, good_vec());
        run(0, 4, -1, '0, cyc, b0, d0);
        checks++;
        if (b0 !== 1'b1 || d0 !== 1'b0) begin
            n_err++; $display("FAIL loopback_start busy/done: got %b%b expected 10", b0, d0);
        end
        checks++;
        if (cyc != 6) begin n_err++; $display("FAIL loopback_done_edge: got %0d expected 6", cyc); end
        checks++;
        if ({vecnum[0], errors[0], pass[0], busy[0]} !== {5'd4, 16'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL loopback_result: vecnum %0d errors %0d pass %b busy %b expected 4 0 1 0",
                              vecnum[0], errors[0], pass[0], busy[0]);
        end
        checks++;
        if (mm_cnt[0] != 0) begin n_err++; $display("FAIL loopback_mismatch: got %0d pulses expected 0", mm_cnt[0]); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (stim_log[1+k] !== vec_stim(tbl[0][k])) begin
                n_err++; $display("FAIL loopback_stim v%0d: got %h expected %h", k, stim_log[1+k], vec_stim(tbl[0][k]));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stim(0) !== vec_stim(tbl[0][3]) || done[0] !== 1'b1) begin
            n_err++; $display("FAIL loopback_hold: stim %h done %b expected %h 1", stim(0), done[0], vec_stim(tbl[0][3]));
        end
    endtask

    task automatic test_mismatch();
        int cyc; logic b0, d0; tvec_t v;
        for (int k = 0; k < 4; k++) begin
            v = good_vec();
            if (k == 2) begin v.din = 8'h3C; v.dexp = 8'h5A; end
            load_vec(0, k, v);
        end
        run(0, 4, -1, '0, cyc, b0, d0);
        checks++;
        if (d0 !== 1'b0) begin n_err++; $display("FAIL mismatch_done_cleared: got %b expected 0", d0); end
        checks++;
        if (mm_cnt[0] != 1 || mm_idx[0] != 2) begin
            n_err++; $display("FAIL mismatch_pulse: got %0d pulses idx %0d expected 1 pulse idx 2", mm_cnt[0], mm_idx[0]);
        end
        checks++;
        if ({errors[0], fail_idx[0], pass[0], done[0]} !== {16'd1, 4'd2, 1'b0, 1'b1} || cyc != 6) begin
            n_err++; $display("FAIL mismatch_result: errors %0d fail_idx %0d pass %b done %b edge %0d expected 1 2 0 1 6",
                              errors[0], fail_idx[0], pass[0], done[0], cyc);
        end
    endtask

    task automatic test_random_runs();
        int cyc, n, errs, lastf, lat; logic b0, d0; tvec_t v;
        for (int it = 0; it < 4; it++) begin
            for (int inst = 0; inst < 2; inst++) begin
                lat = (inst == 0) ? 1 : 3;
                n = $urandom_range(1, D);
                for (int k = 0; k < n; k++) begin
                    v = good_vec();
                    if ($urandom_range(0, 2) == 0) v = corrupt(v);
                    load_vec(inst, k, v);
                end
                model_run(inst, n, errs, lastf);
                run(inst, n, -1, '0, cyc, b0, d0);
                checks++;
                if (cyc != n + lat + 1) begin
                    n_err++; $display("FAIL rand_run_edge inst%0d n%0d: got %0d expected %0d", inst, n, cyc, n + lat + 1);
                end
                checks++;
                if (vecnum[inst] !== 5'(n) || errors[inst] !== 16'(errs) || pass[inst] !== (errs == 0)) begin
                    n_err++; $display("FAIL rand_run_counts inst%0d: vecnum %0d errors %0d pass %b expected %0d %0d %b",
                                      inst, vecnum[inst], errors[inst], pass[inst], n, errs, errs == 0);
                end
                checks++;
                if (fail_idx[inst] !== 4'(lastf) || mm_cnt[inst] != errs) begin
                    n_err++; $display("FAIL rand_run_fail inst%0d: fail_idx %0d pulses %0d expected %0d %0d",
                                      inst, fail_idx[inst], mm_cnt[inst], lastf, errs);
                end
            end
        end
    endtask

    task automatic test_lat3();
        int cyc0, cyc1; logic b0, d0; tvec_t v;
        for (int k = 0; k < 10; k++) begin
            v = good_vec();
            load_vec(0, k, v);
            load_vec(1, k, v);
        end
        run(0, 10, -1, '0, cyc0, b0, d0);
        run(1, 10, -1, '0, cyc1, b0, d0);
        checks++;
        if (cyc0 != 12 || cyc1 != 14) begin
            n_err++; $display("FAIL lat3_done_edge: got lat1 %0d lat3 %0d expected 12 14", cyc0, cyc1);
        end
        checks++;
        if ({vecnum[1], errors[1], pass[1]} !== {5'd10, 16'd0, 1'b1}) begin
            n_err++; $display("FAIL lat3_result: vecnum %0d errors %0d pass %b expected 10 0 1", vecnum[1], errors[1], pass[1]);
        end
    endtask

    task automatic test_clamp();
        int cyc; logic b0, d0;
        for (int k = 0; k < D; k++) load_vec(0, k, good_vec());
        run(0, 20, -1, '0, cyc, b0, d0);
        checks++;
        if (vecnum[0] !== 5'd16 || cyc != 18 || pass[0] !== 1'b1) begin
            n_err++; $display("FAIL clamp: vecnum %0d edge %0d pass %b expected 16 18 1", vecnum[0], cyc, pass[0]);
        end
    endtask

    task automatic test_rand_phase();
        int cyc; logic b0, d0; logic [15:0] w;
        run(2, 0, -1, '0, cyc, b0, d0);
        checks++;
        if (stim_log[1][14:7] !== 8'hE1) begin
            n_err++; $display("FAIL rand_first_word: got %h expected e1", stim_log[1][14:7]);
        end
        checks++;
        if (cyc != 30 || vecnum[2] !== 5'd0 || pass[2] !== 1'b1 || b0 !== 1'b1) begin
            n_err++; $display("FAIL rand_only: edge %0d vecnum %0d pass %b busy0 %b expected 30 0 1 1", cyc, vecnum[2], pass[2], b0);
        end
        w = 16'hACE1;
        for (int j = 0; j < 30; j++) begin
            checks++;
            if (stim_log[1+j] !== word_stim(w)) begin
                n_err++; $display("FAIL rand_stim word%0d: got %h expected %h", j, stim_log[1+j], word_stim(w));
            end
            w = lfsr_step(w);
        end
        for (int k = 0; k < 3; k++) load_vec(2, k, good_vec());
        run(2, 3, -1, '0, cyc, b0, d0);
        checks++;
        if (cyc != 35 || vecnum[2] !== 5'd3 || errors[2] !== 16'd0) begin
            n_err++; $display("FAIL vec_then_rand: edge %0d vecnum %0d errors %0d expected 35 3 0", cyc, vecnum[2], errors[2]);
        end
        checks++;
        if (stim_log[6] !== word_stim(16'hACE1) || stim_log[3] !== vec_stim(tbl[2][2])) begin
            n_err++; $display("FAIL vec_then_rand_stim: got %h %h expected %h %h",
                              stim_log[3], stim_log[6], vec_stim(tbl[2][2]), word_stim(16'hACE1));
        end
    endtask

    task automatic test_ignore_busy();
        int cyc; logic b0, d0; tvec_t bad;
        for (int k = 0; k < 8; k++) load_vec(0, k, good_vec());
        bad = tbl[0][5];
        bad.din = 8'h11;
        bad.dexp = 8'h22;
        run(0, 8, 2, bad, cyc, b0, d0);
        checks++;
        if (cyc != 10 || vecnum[0] !== 5'd8 || errors[0] !== 16'd0) begin
            n_err++; $display("FAIL ignore_busy: edge %0d vecnum %0d errors %0d expected 10 8 0", cyc, vecnum[0], errors[0]);
        end
        run(0, 8, -1, '0, cyc, b0, d0);
        checks++;
        if (stim_log[6] !== vec_stim(tbl[0][5]) || errors[0] !== 16'd0) begin
            n_err++; $display("FAIL ignore_table: v5 stim %h errors %0d expected %h 0", stim_log[6], errors[0], vec_stim(tbl[0][5]));
        end
    endtask

    task automatic test_reset_midrun();
        int cyc; logic b0, d0;
        for (int k = 0; k < 8; k++) load_vec(0, k, good_vec());
        num_vec[0] = 5'd8;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (stim(0) !== vec_stim(tbl[0][2]) || vecnum[0] !== 5'd2) begin
            n_err++; $display("FAIL midrun_before_rst: stim %h vecnum %0d expected %h 2", stim(0), vecnum[0], vec_stim(tbl[0][2]));
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy[0], done[0], pass[0], mismatch[0], vecnum[0], errors[0], fail_idx[0], stim(0)} !== '0) begin
            n_err++; $display("FAIL midrun_rst: busy %b done %b vecnum %0d errors %0d stim %h expected all 0",
                              busy[0], done[0], vecnum[0], errors[0], stim(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, 8, -1, '0, cyc, b0, d0);
        checks++;
        if (cyc != 10 || vecnum[0] !== 5'd8 || errors[0] !== 16'd0 || pass[0] !== 1'b1) begin
            n_err++; $display("FAIL midrun_restart: edge %0d vecnum %0d errors %0d pass %b expected 10 8 0 1",
                              cyc, vecnum[0], errors[0], pass[0]);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_mismatch();
        test_random_runs();
        test_lat3();
        test_clamp();
        test_rand_phase();
        test_ignore_busy();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, n_err);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Synthesizable stimulus/response engine that sits directly in front of, and directly behind, the `file` datapath block. It holds a loadable table of test vectors, each packing {data_in, a, b, x, data_out_exp, out_exp, d_exp}. It drives the stimulus fields into `file` one vector per cycle and compares `file`'s outputs against the expected fields after a fixed latency. It then runs an optional free-running pseudo-random stimulus phase and reports vector count, error count and pass/fail.

## Interface
Parameters:
- `WIDTH`, 8, width of data_in / data_out fields
- `X_W`, 5, width of x field
- `DEPTH`, 16, vector table entries
- `LAT`, 1, edges from stimulus update to response sample (≥1; 1 = combinational DUT)
- `RAND_CYCLES`, 30, cycles of random stimulus after table phase (0 = skip)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `load_en` in 1: write `load_data` to table[`load_addr`]
- `load_addr` in clog2(DEPTH): table write address
- `load_data` in VEC_W: packed vector, VEC_W = 2*WIDTH+X_W+4
- `num_vec` in clog2(DEPTH)+1: vectors to run, sampled at start
- `start` in 1: begin run (pulse)
- `data_in_o` out WIDTH: stimulus to DUT
- `a_o`, `b_o` out 1: stimulus to DUT
- `x_o` out X_W: stimulus to DUT
- `data_out_i` in WIDTH: DUT response
- `out_i`, `d_i` in 1: DUT response
- `busy` out 1: run in progress
- `done` out 1: level, run finished; cleared by next accepted start
- `pass` out 1: done && errors==0
- `mismatch` out 1: one-cycle pulse on a failed compare
- `fail_idx` out clog2(DEPTH): index of most recent failing vector
- `vecnum` out clog2(DEPTH)+1: vectors compared so far
- `errors` out 16: failed compares, saturating at 16'hFFFF

## Operation
- Packing, MSB→LSB: data_in, a, b, x, data_out_exp, out_exp, d_exp.
- FSM states:
  - IDLE → RUN on `start` when num_vec>0.
  - IDLE → RAND on `start` when num_vec==0 and RAND_CYCLES>0.
  - IDLE → DONE on `start` when num_vec==0 and RAND_CYCLES==0.
  - RUN: issues one vector per cycle; after the last issue → DRAIN.
  - DRAIN: waits until the expected-value pipe is empty → RAND, or → DONE if RAND_CYCLES==0.
  - RAND: counts RAND_CYCLES cycles → DONE.
  - DONE → RUN/RAND/DONE on the next `start`, using the same rules as IDLE.
- Accepting start clears errors, vecnum, fail_idx and done.
- Issue: at each RUN edge, stimulus outputs load table[k] stimulus fields. The expected fields plus valid enter an LAT-deep delay pipe.
- Compare: when the pipe output is valid at an edge, compare it with {data_out_i, out_i, d_i}.
  - Always increment vecnum.
  - On inequality, increment errors (saturating), pulse mismatch and set fail_idx=k.
- RAND: stimulus fields come from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded at each start). Each cycle, data_in=lfsr[WIDTH-1:0], a=lfsr[8], b=lfsr[9], x=lfsr[X_W+9:10]. No compares in RAND.
- In IDLE/DONE the stimulus outputs hold their last value.
- `load_en` is honoured only when busy==0; ignored otherwise. The table is not reset.
- `start` while busy is ignored. num_vec>DEPTH is clamped to DEPTH.

## Timing
- Reset values: stimulus outputs 0, busy 0, done 0, pass 0, mismatch 0, fail_idx 0, vecnum 0, errors 0, state IDLE, pipe valid bits 0.
- `start` at edge E0 → busy=1 after E0; vector 0 on stimulus outputs after E1; vector k after E(1+k).
- Vector k is compared at edge E(1+k+LAT); mismatch is high in the cycle after that edge.
- Last compare at E(num_vec+LAT).
  - RAND_CYCLES==0: done=1, busy=0 after E(num_vec+LAT+1).
  - RAND_CYCLES>0: RAND occupies the next RAND_CYCLES cycles, then done.
- Table write at an edge is visible to a start accepted at the same edge or later. Issue reads are combinational from the table array; stimulus outputs are registered.
- `rst` mid-run: all state returns to reset values immediately; the pipe is flushed; no partial counts are retained.

## Structure
- Package `vec_pkg`:
  - VEC_W function and field-offset constants
  - state enum {IDLE, RUN, DRAIN, RAND, DONE}
  - LFSR seed and tap constants
- Sub-module `exp_delay`: a parameterized LAT-deep shift register carrying {valid, index, expected fields}, with async reset of valid bits only.
- Top level contains the table, FSM, issue counter, RAND counter, LFSR and compare/count logic.

## Test plan
- Loopback wiring (data_out_i=data_in_o, out_i=a_o, d_i=b_o), LAT=1, 4 vectors with matching expectations, RAND_CYCLES=0 → vecnum=4, errors=0, pass=1, done 6 edges after start.
- Same setup with vector 2's data_out_exp corrupted to 8'h5A → a single mismatch pulse, fail_idx=2, errors=1, pass=0.
- LAT=3 with a 2-register delay on the loopback path, 10 vectors → all pass; done edge shifts by +2 versus LAT=1.
- num_vec=0, RAND_CYCLES=30 → first LFSR word 16'hACE1 drives data_in_o=8'hE1; done after 30 cycles; vecnum=0.
- Assert `start` and `load_en` during RUN → both ignored, table unchanged. Assert rst at the 3rd vector → all outputs return to 0 immediately; a restart then rereads the retained table and passes.
